ram_sdp_ctrl: RTL
=================

// Module: ram_sdp_ctrl
// PURPOSE
// - Parametrised simple-dual-port synchronous RAM (1 write port, 1 read port) with separate data buses, byte enables,
//   configurable read latency and a built-in clear engine that fills the array with INIT_VAL after reset or on request.
// - Next-generation storage for FSM/datapath blocks: no tri-state bus; read results carry a valid strobe.
// PARAMETERS
// - DATA_W     32       data width in bits; must be a multiple of 8
// - DEPTH      1024     number of words; any value >= 2
// - ADDR_W     10       address width; must equal $clog2(DEPTH)
// - RD_LAT     1        read latency in cycles, 1 or 2 (2 adds an output register)
// - BYPASS     1        1 = write-first on same-address collision, 0 = read-first (old data)
// - INIT_VAL   0        word value written to every location by the clear engine
// PORTS
// - clk        in   1          rising-edge clock
// - rst_n      in   1          asynchronous active-low reset
// - clear      in   1          pulse: restart clear engine (ignored while clearing)
// - init_done  out  1          1 = array cleared, ports accept traffic
// - wr_en      in   1          write request
// - wr_addr    in   ADDR_W     write address
// - wr_data    in   DATA_W     write data
// - wr_be      in   DATA_W/8   byte enables, bit i covers wr_data[8i+7:8i]
// - rd_en      in   1          read request
// - rd_addr    in   ADDR_W     read address
// - rd_valid   out  1          rd_data valid this cycle (single-cycle strobe per accepted read)
// - rd_data    out  DATA_W     read data
// BEHAVIOUR
// - Reset (rst_n=0, async): FSM -> CLEAR, clear counter = 0, init_done=0, rd_valid=0, rd_data=0, pipeline flushed.
// - FSM states: CLEAR, READY.
//   CLEAR: each cycle write INIT_VAL to mem[cnt], cnt++; at cnt==DEPTH-1 write last word, go READY next cycle.
//   CLEAR lasts exactly DEPTH cycles; init_done rises the cycle after the final clear write.
//   READY: init_done=1; clear=1 -> CLEAR with cnt=0, init_done drops next cycle; in-flight reads still complete.
// - wr_en/rd_en sampled only when init_done=1; in CLEAR they are dropped silently (no rd_valid generated).
// - Write: on posedge with wr_en, bytes with wr_be[i]=1 updated; wr_be=0 is a no-op.
// - Read: rd_en accepted at edge N -> rd_valid=1 and rd_data at edge N+RD_LAT; one result per request, fully pipelined,
//   back-to-back reads every cycle supported. rd_data holds last value when rd_valid=0.
// - Collision (wr_en & rd_en, same addr, same edge): BYPASS=1 -> returned word = old word with enabled bytes
//   replaced by wr_data; BYPASS=0 -> old word. Different addresses: independent.
// - Out-of-range address (>= DEPTH, only when DEPTH not power of 2): write ignored; read returns 0 with rd_valid=1.
// - Reset mid-operation: pending read results discarded (no rd_valid), array contents re-cleared.
// - clear asserted same cycle as a write: write performed, then CLEAR overwrites it.
// STRUCTURE
// - ram_pkg: state enum (ST_CLEAR, ST_READY), byte-merge function merge_be(old,new,be), clog2 helper.
// - Sub-module ram_sdp_core: array, byte-enable write, read register, collision bypass; no reset on array.
// - Top ram_sdp_ctrl: clear FSM + counter, port muxing (clear vs user write), valid pipeline, optional RD_LAT=2 stage.
// TESTING
// - Reset release, DEPTH=16: init_done=0 for 16 cycles, =1 on cycle 17; read all addrs -> each returns INIT_VAL.
// - Write 0xDEADBEEF @5 be=4'b1111, then wr 0x000000AA @5 be=4'b0001; read @5 -> 0xDEADBEAA, rd_valid after RD_LAT.
// - Same-edge wr 0x12345678 @3 (be=1111) + rd @3, old=0: BYPASS=1 -> 0x12345678; BYPASS=0 -> 0x00000000.
// - Back-to-back reads @0..7 every cycle, RD_LAT=2 -> 8 consecutive rd_valid pulses, data in order, 2-cycle latency.
// - Reads issued during CLEAR -> no rd_valid; clear pulse in READY after write 0x55 @2 -> @2 reads INIT_VAL later.
// - rst_n low while 2 reads in flight -> rd_valid stays 0, rd_data=0; after DEPTH cycles init_done=1 again.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and helpers for the simple-dual-port RAM controller.
package ram_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_READY
  } state_t;

  // Widest data bus the byte-merge helper supports; callers zero-extend into it.
  localparam int MAX_DATA_W = 256;

  function automatic logic [MAX_DATA_W-1:0] merge_be(
    input logic [MAX_DATA_W-1:0]   old_w,
    input logic [MAX_DATA_W-1:0]   new_w,
    input logic [MAX_DATA_W/8-1:0] be
  );
    logic [MAX_DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < MAX_DATA_W / 8; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_sdp_core.sv
// Storage array with byte-enable write port, registered read port and
// optional write-first bypass on same-address collisions.
module ram_sdp_core
  import ram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata
);

  localparam int NB      = DATA_W / 8;
  localparam bit IS_POW2 = (DEPTH == (1 << clog2(DEPTH)));

  logic [DATA_W-1:0] mem [DEPTH];
  logic              wr_ok;
  logic              rd_ok;
  logic [DATA_W-1:0] rd_word;

  // Addresses past DEPTH exist only when DEPTH is not a power of two.
  assign wr_ok = IS_POW2 || (32'(waddr) < DEPTH);
  assign rd_ok = IS_POW2 || (32'(raddr) < DEPTH);

  // NOTE: the array has no reset so it maps onto block RAM; the clear engine
  // in the parent provides the defined initial contents instead.
  always_ff @(posedge clk) begin
    if (we && wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    logic [MAX_DATA_W-1:0]   old_ext;
    logic [MAX_DATA_W-1:0]   new_ext;
    logic [MAX_DATA_W/8-1:0] be_ext;
    logic [MAX_DATA_W-1:0]   merged;
    old_ext = '0;
    new_ext = '0;
    be_ext  = '0;
    old_ext[DATA_W-1:0] = mem[raddr];
    new_ext[DATA_W-1:0] = wdata;
    be_ext[NB-1:0]      = wbe;
    merged  = merge_be(old_ext, new_ext, be_ext);
    rd_word = '0;
    if (rd_ok) begin
      if (BYPASS != 0 && we && wr_ok && waddr == raddr) rd_word = merged[DATA_W-1:0];
      else                                              rd_word = mem[raddr];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= rd_word;
  end

endmodule

// File: rtl/ram_sdp_ctrl.sv
// Simple-dual-port RAM with clear engine, read-valid pipeline and
// selectable 1- or 2-cycle read latency.
module ram_sdp_ctrl
  import ram_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 1024,
  parameter int                ADDR_W   = 10,
  parameter int                RD_LAT   = 1,
  parameter int                BYPASS   = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  output logic                init_done,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                rd_valid,
  output logic [DATA_W-1:0]   rd_data
);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt, cnt_nxt;
  logic                core_we;
  logic [ADDR_W-1:0]   core_waddr;
  logic [DATA_W-1:0]   core_wdata;
  logic [DATA_W/8-1:0] core_wbe;
  logic                rd_acc;
  logic                v1;
  logic [DATA_W-1:0]   core_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      ST_CLEAR: begin
        if (cnt == ADDR_W'(DEPTH - 1)) state_nxt = ST_READY;
        else                           cnt_nxt   = cnt + 1'b1;
      end
      ST_READY: begin
        if (clear) state_nxt = ST_CLEAR;
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  assign init_done = (state == ST_READY);
  assign rd_acc    = init_done && rd_en;

  // While clearing the engine owns the write port and user traffic is dropped.
  always_comb begin
    core_we    = init_done && wr_en;
    core_waddr = wr_addr;
    core_wdata = wr_data;
    core_wbe   = wr_be;
    if (!init_done) begin
      core_we    = 1'b1;
      core_waddr = cnt;
      core_wdata = INIT_VAL;
      core_wbe   = '1;
    end
  end

  ram_sdp_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (core_we),
    .waddr (core_waddr),
    .wdata (core_wdata),
    .wbe   (core_wbe),
    .re    (rd_acc),
    .raddr (rd_addr),
    .rdata (core_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v1 <= 1'b0;
    else        v1 <= rd_acc;
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              v2;
      logic [DATA_W-1:0] data2;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v2    <= 1'b0;
          data2 <= '0;
        end else begin
          v2 <= v1;
          if (v1) data2 <= core_rdata;
        end
      end
      assign rd_valid = v2;
      assign rd_data  = data2;
    end else begin : g_lat1
      assign rd_valid = v1;
      assign rd_data  = core_rdata;
    end
  endgenerate

endmodule
